// File: rtl/sc_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sc_cfg_scheduler
// Purpose  : Double-buffered configuration scheduler. Eight 32-bit shadow
//            registers are written at any time. A commit request applies the
//            dirty shadows to the active outputs on the next falling edge of
//            the active-low VSYNC, or after TIMEOUT_CLKS cycles without an
//            edge.
// Ports    : PCLK_i            - sole clock, rising edge
//            reset             - synchronous active-high reset
//            VSYNC_i           - active-low vertical sync
//            cfg_wr_i          - shadow write strobe
//            cfg_sel_i         - shadow select (0..7)
//            cfg_data_i        - shadow write data
//            cfg_commit_i      - request apply at next frame boundary
//            cfg_busy_o        - scheduler not idle
//            cfg_done_o        - one-cycle commit-complete pulse
//            cfg_timeout_o     - commit was forced by timeout (with done)
//            resync_o          - any of registers 0-4 applied (with done)
//            *_config*_o       - active configuration registers
// Revision : 1.0 - initial release
// ============================================================================
module sc_cfg_scheduler #(
    parameter logic [21:0] TIMEOUT_CLKS = 22'd2000000
) (
    input  logic        PCLK_i,
    input  logic        reset,
    input  logic        VSYNC_i,
    input  logic        cfg_wr_i,
    input  logic [2:0]  cfg_sel_i,
    input  logic [31:0] cfg_data_i,
    input  logic        cfg_commit_i,
    output logic        cfg_busy_o,
    output logic        cfg_done_o,
    output logic        cfg_timeout_o,
    output logic        resync_o,
    output logic [31:0] hv_out_config_o,
    output logic [31:0] hv_out_config2_o,
    output logic [31:0] hv_out_config3_o,
    output logic [31:0] xy_out_config_o,
    output logic [31:0] xy_out_config2_o,
    output logic [31:0] misc_config_o,
    output logic [31:0] sl_config_o,
    output logic [31:0] sl_config2_o
);

    localparam logic [21:0] c_CNT_LIMIT = TIMEOUT_CLKS - 22'd1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_APPLY   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_vs_prev;
    logic        w_vs_fall;
    logic [31:0] r_shadow [8];
    logic [31:0] r_active [8];
    logic [7:0]  r_dirty;
    logic [7:0]  w_wr_mask;
    logic [7:0]  w_apply_mask;
    logic [21:0] r_cnt;
    logic        r_timeout;
    logic        r_resync;
    logic        w_start_pend;
    logic        w_timeout_hit;

    assign w_vs_fall    = r_vs_prev & ~VSYNC_i;
    assign w_wr_mask    = cfg_wr_i ? (8'd1 << cfg_sel_i) : 8'd0;
    // Only the bits that were dirty when APPLY began are consumed; a write
    // landing in the APPLY cycle re-sets its bit and waits for a later commit.
    assign w_apply_mask = (r_state == S_APPLY) ? r_dirty : 8'd0;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_start_pend  = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A VSYNC edge in the commit cycle itself is deliberately
                // ignored: the apply waits for the following edge.
                if (cfg_commit_i) begin
                    if (r_dirty != 8'd0) begin
                        w_state_nxt  = S_PENDING;
                        w_start_pend = 1'b1;
                    end else begin
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_PENDING: begin
                // Edge has priority over the timeout limit.
                if (w_vs_fall) begin
                    w_state_nxt   = S_APPLY;
                end else if (r_cnt == c_CNT_LIMIT) begin
                    w_state_nxt   = S_APPLY;
                    w_timeout_hit = 1'b1;
                end
            end
            S_APPLY: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: edge detect, counter, shadows, dirty mask, active regs
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            r_vs_prev <= 1'b0;
            r_cnt     <= 22'd0;
            r_dirty   <= 8'd0;
            r_timeout <= 1'b0;
            r_resync  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 32'd0;
                r_active[i] <= 32'd0;
            end
        end else begin
            r_vs_prev <= VSYNC_i;

            if (w_start_pend) begin
                r_cnt <= 22'd0;
            end else if (r_state == S_PENDING) begin
                r_cnt <= r_cnt + 22'd1;
            end

            // Flags are cleared while idle so an empty commit reports neither.
            if (r_state == S_IDLE) begin
                r_timeout <= 1'b0;
                r_resync  <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end

            if (r_state == S_APPLY) begin
                r_resync <= |r_dirty[4:0];
                for (int i = 0; i < 8; i++) begin
                    if (r_dirty[i]) begin
                        r_active[i] <= r_shadow[i];
                    end
                end
            end

            if (cfg_wr_i) begin
                r_shadow[cfg_sel_i] <= cfg_data_i;
            end

            r_dirty <= (r_dirty & ~w_apply_mask) | w_wr_mask;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_busy_o       = (r_state != S_IDLE);
    assign cfg_done_o       = (r_state == S_DONE);
    assign cfg_timeout_o    = cfg_done_o & r_timeout;
    assign resync_o         = cfg_done_o & r_resync;

    assign hv_out_config_o  = r_active[0];
    assign hv_out_config2_o = r_active[1];
    assign hv_out_config3_o = r_active[2];
    assign xy_out_config_o  = r_active[3];
    assign xy_out_config2_o = r_active[4];
    assign misc_config_o    = r_active[5];
    assign sl_config_o      = r_active[6];
    assign sl_config2_o     = r_active[7];

endmodule
`default_nettype wire

// File: tb/tb_sc_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_cfg_scheduler
// Purpose  : Directed self-checking bench for sc_cfg_scheduler. Instance A
//            uses the default timeout; instance B uses TIMEOUT_CLKS=16 for
//            the timeout scenarios. VSYNC and reset are shared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_cfg_scheduler;

    logic        PCLK_i;
    logic        reset;
    logic        VSYNC_i;

    logic        a_wr, a_commit;
    logic [2:0]  a_sel;
    logic [31:0] a_data;
    logic        a_busy, a_done, a_timeout, a_resync;
    logic [31:0] a_hv, a_hv2, a_hv3, a_xy, a_xy2, a_misc, a_sl, a_sl2;

    logic        b_wr, b_commit;
    logic [2:0]  b_sel;
    logic [31:0] b_data;
    logic        b_busy, b_done, b_timeout, b_resync;
    logic [31:0] b_hv, b_hv2, b_hv3, b_xy, b_xy2, b_misc, b_sl, b_sl2;

    int n_assert = 0;
    int n_fail   = 0;

    sc_cfg_scheduler dut_a (
        .PCLK_i           (PCLK_i),
        .reset            (reset),
        .VSYNC_i          (VSYNC_i),
        .cfg_wr_i         (a_wr),
        .cfg_sel_i        (a_sel),
        .cfg_data_i       (a_data),
        .cfg_commit_i     (a_commit),
        .cfg_busy_o       (a_busy),
        .cfg_done_o       (a_done),
        .cfg_timeout_o    (a_timeout),
        .resync_o         (a_resync),
        .hv_out_config_o  (a_hv),
        .hv_out_config2_o (a_hv2),
        .hv_out_config3_o (a_hv3),
        .xy_out_config_o  (a_xy),
        .xy_out_config2_o (a_xy2),
        .misc_config_o    (a_misc),
        .sl_config_o      (a_sl),
        .sl_config2_o     (a_sl2)
    );

    sc_cfg_scheduler #(.TIMEOUT_CLKS(22'd16)) dut_b (
        .PCLK_i           (PCLK_i),
        .reset            (reset),
        .VSYNC_i          (VSYNC_i),
        .cfg_wr_i         (b_wr),
        .cfg_sel_i        (b_sel),
        .cfg_data_i       (b_data),
        .cfg_commit_i     (b_commit),
        .cfg_busy_o       (b_busy),
        .cfg_done_o       (b_done),
        .cfg_timeout_o    (b_timeout),
        .resync_o         (b_resync),
        .hv_out_config_o  (b_hv),
        .hv_out_config2_o (b_hv2),
        .hv_out_config3_o (b_hv3),
        .xy_out_config_o  (b_xy),
        .xy_out_config2_o (b_xy2),
        .misc_config_o    (b_misc),
        .sl_config_o      (b_sl),
        .sl_config2_o     (b_sl2)
    );

    initial PCLK_i = 1'b0;
    always #5 PCLK_i = ~PCLK_i;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge PCLK_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [2:0] sel, input logic [31:0] data);
        a_wr = 1'b1; a_sel = sel; a_data = data;
        tick();
        a_wr = 1'b0;
    endtask

    task automatic b_write(input logic [2:0] sel, input logic [31:0] data);
        b_wr = 1'b1; b_sel = sel; b_data = data;
        tick();
        b_wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; VSYNC_i = 1'b1;
        a_wr = 1'b0; a_commit = 1'b0; a_sel = 3'd0; a_data = 32'd0;
        b_wr = 1'b0; b_commit = 1'b0; b_sel = 3'd0; b_data = 32'd0;
        tick(); tick();

        // ---------------- reset state ----------------
        check("rst_busy",  {31'd0, a_busy},    32'd0);
        check("rst_done",  {31'd0, a_done},    32'd0);
        check("rst_hv",    a_hv,               32'd0);
        check("rst_sl2",   a_sl2,              32'd0);
        reset = 1'b0;
        tick();

        // ---------------- write sel0, commit, edge 100 cycles later ----------------
        a_write(3'd0, 32'h12345678);
        a_commit = 1'b1;
        check("t1_busy_commit_cycle", {31'd0, a_busy}, 32'd0);
        tick();
        a_commit = 1'b0;
        check("t1_busy_pending", {31'd0, a_busy}, 32'd1);
        for (int i = 0; i < 99; i++) begin
            tick();
            check("t1_wait_busy", {31'd0, a_busy}, 32'd1);
            check("t1_wait_done", {31'd0, a_done}, 32'd0);
        end
        check("t1_hv_before_edge", a_hv, 32'd0);
        VSYNC_i = 1'b0;          // edge-detect cycle
        tick();
        VSYNC_i = 1'b1;
        check("t1_apply_done", {31'd0, a_done}, 32'd0);
        check("t1_apply_hv",   a_hv,               32'd0);
        tick();
        check("t1_done",       {31'd0, a_done},    32'd1);
        check("t1_resync",     {31'd0, a_resync},  32'd1);
        check("t1_timeout",    {31'd0, a_timeout}, 32'd0);
        check("t1_busy_done",  {31'd0, a_busy},    32'd1);
        check("t1_hv",         a_hv,               32'h12345678);
        tick();
        check("t1_idle_done",  {31'd0, a_done},    32'd0);
        check("t1_idle_busy",  {31'd0, a_busy},    32'd0);
        check("t1_idle_hv",    a_hv,               32'h12345678);

        // ---------------- write sel6, no resync ----------------
        a_write(3'd6, 32'h000000A5);
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        tick(); tick();
        VSYNC_i = 1'b0;
        tick();
        VSYNC_i = 1'b1;
        tick();
        check("t2_done",   {31'd0, a_done},   32'd1);
        check("t2_resync", {31'd0, a_resync}, 32'd0);
        check("t2_sl",     a_sl,              32'h000000A5);
        check("t2_hv",     a_hv,              32'h12345678);
        check("t2_sl2",    a_sl2,             32'd0);
        tick();

        // ---------------- empty commit ----------------
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        check("t3_done",    {31'd0, a_done},    32'd1);
        check("t3_busy",    {31'd0, a_busy},    32'd1);
        check("t3_resync",  {31'd0, a_resync},  32'd0);
        check("t3_timeout", {31'd0, a_timeout}, 32'd0);
        tick();
        check("t3_idle_busy", {31'd0, a_busy}, 32'd0);
        check("t3_idle_done", {31'd0, a_done}, 32'd0);

        // ---------------- write in APPLY deferred; write in PENDING included ----------------
        a_write(3'd5, 32'h0000BEEF);
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        a_write(3'd7, 32'h00000077);     // during PENDING
        tick();
        VSYNC_i = 1'b0;
        tick();                          // now in APPLY
        VSYNC_i = 1'b1;
        a_write(3'd1, 32'h00000001);     // write lands in APPLY cycle -> now DONE
        check("t4_done",   {31'd0, a_done},   32'd1);
        check("t4_misc",   a_misc,            32'h0000BEEF);
        check("t4_sl2",    a_sl2,             32'h00000077);
        check("t4_hv2",    a_hv2,             32'd0);
        check("t4_resync", {31'd0, a_resync}, 32'd0);
        tick();
        check("t4_idle_hv2", a_hv2, 32'd0);
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        check("t4_recommit_busy", {31'd0, a_busy}, 32'd1);
        tick();
        VSYNC_i = 1'b0;
        tick();
        VSYNC_i = 1'b1;
        tick();
        check("t4b_done",   {31'd0, a_done},   32'd1);
        check("t4b_hv2",    a_hv2,             32'h00000001);
        check("t4b_resync", {31'd0, a_resync}, 32'd1);
        check("t4b_misc",   a_misc,            32'h0000BEEF);
        tick();

        // ---------------- timeout (instance B, limit 16) ----------------
        b_write(3'd3, 32'hCAFE0003);
        b_commit = 1'b1;
        tick();                          // PENDING cycle 1
        b_commit = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();                      // PENDING cycles 2..16
            check("t5_pend_done", {31'd0, b_done}, 32'd0);
            check("t5_pend_busy", {31'd0, b_busy}, 32'd1);
        end
        tick();                          // APPLY
        check("t5_apply_done", {31'd0, b_done}, 32'd0);
        check("t5_apply_xy",   b_xy,            32'd0);
        tick();                          // DONE
        check("t5_done",    {31'd0, b_done},    32'd1);
        check("t5_timeout", {31'd0, b_timeout}, 32'd1);
        check("t5_resync",  {31'd0, b_resync},  32'd1);
        check("t5_xy",      b_xy,               32'hCAFE0003);
        tick();
        check("t5_idle_timeout", {31'd0, b_timeout}, 32'd0);

        // ---------------- edge coincident with limit: edge wins ----------------
        b_write(3'd2, 32'h00000003);
        b_commit = 1'b1;
        tick();                          // PENDING cycle 1
        b_commit = 1'b0;
        for (int i = 0; i < 15; i++) tick();   // PENDING cycle 16 (limit)
        VSYNC_i = 1'b0;
        tick();                          // APPLY
        VSYNC_i = 1'b1;
        tick();                          // DONE
        check("t6_done",    {31'd0, b_done},    32'd1);
        check("t6_timeout", {31'd0, b_timeout}, 32'd0);
        check("t6_hv3",     b_hv3,              32'h00000003);
        tick();

        // ---------------- reset during PENDING ----------------
        a_write(3'd4, 32'h00000044);
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_busy", {31'd0, a_busy}, 32'd0);
        check("t7_done", {31'd0, a_done}, 32'd0);
        check("t7_hv",   a_hv,            32'd0);
        check("t7_misc", a_misc,          32'd0);
        check("t7_sl",   a_sl,            32'd0);
        tick();
        VSYNC_i = 1'b0;
        tick();
        VSYNC_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t7_post_done", {31'd0, a_done}, 32'd0);
            check("t7_post_busy", {31'd0, a_busy}, 32'd0);
            check("t7_post_xy2",  a_xy2,           32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sc_cfg_scheduler.md
SC_CFG_SCHEDULER -- requirements
Module: sc_cfg_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 22'd2000000: PCLK cycles to wait for a VSYNC edge before forcing a commit.
REQ-002 SHALL have port PCLK_i, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port VSYNC_i, input, 1: active-low vertical sync from the capture path.
REQ-005 SHALL have port cfg_wr_i, input, 1: single-cycle shadow-register write strobe.
REQ-006 SHALL have port cfg_sel_i, input, 3: write target. 0=hv_out_config, 1=hv_out_config2, 2=hv_out_config3, 3=xy_out_config, 4=xy_out_config2, 5=misc_config, 6=sl_config, 7=sl_config2.
REQ-007 SHALL have port cfg_data_i, input, 32: write data.
REQ-008 SHALL have port cfg_commit_i, input, 1: single-cycle request to apply the dirty shadows at the next frame boundary.
REQ-009 SHALL have port cfg_busy_o, output, 1: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port cfg_done_o, output, 1: one-cycle pulse when a commit completes.
REQ-011 SHALL have port cfg_timeout_o, output, 1: one-cycle pulse, coincident with cfg_done_o, when the commit was forced by timeout.
REQ-012 SHALL have port resync_o, output, 1: one-cycle pulse, coincident with cfg_done_o, when any of registers 0-4 was applied.
REQ-013 SHALL have ports hv_out_config_o, hv_out_config2_o, hv_out_config3_o, xy_out_config_o, xy_out_config2_o, misc_config_o, sl_config_o, sl_config2_o, all outputs, 32 each: active configuration.

Function
REQ-014 SHALL hold eight 32-bit shadow registers and an 8-bit dirty mask; cfg_wr_i writes shadow[cfg_sel_i] and sets dirty[cfg_sel_i] in the same cycle.
REQ-015 SHALL detect a VSYNC falling edge as vs_prev=1 and VSYNC_i=0, with vs_prev being VSYNC_i registered each cycle.
REQ-016 SHALL implement FSM states IDLE, PENDING, APPLY, DONE.
REQ-017 SHALL move IDLE->PENDING on cfg_commit_i when dirty!=0; an edge in the same cycle SHALL NOT be used, so the FSM waits for the next edge.
REQ-018 SHALL move IDLE->DONE on cfg_commit_i when dirty==0, with no APPLY, resync_o=0 and cfg_timeout_o=0.
REQ-019 SHALL, in PENDING, clear a 22-bit counter on entry and increment it each cycle; a falling edge moves to APPLY.
REQ-020 SHALL move PENDING->APPLY with the timeout flag set when the counter reaches TIMEOUT_CLKS-1 and no edge occurs; if an edge and the limit coincide, the edge wins and the flag stays clear.
REQ-021 SHALL, on the clock edge ending APPLY, copy every dirty shadow to its active output, latch the resync condition (dirty[4:0]!=0), clear the copied dirty bits, and move to DONE.
REQ-022 SHALL, in DONE, assert cfg_done_o, and assert resync_o and cfg_timeout_o as latched; new active values SHALL be visible in this same cycle; DONE->IDLE unconditionally.
REQ-023 SHALL give a latency of 2 cycles from the edge-detect cycle to the cfg_done_o cycle.
REQ-024 SHALL accept writes during PENDING; they are included in the pending apply.
REQ-025 SHALL handle a write in the APPLY cycle as follows: it updates the shadow and leaves its dirty bit set; it is not applied, and it waits for the next commit.
REQ-026 SHALL ignore cfg_commit_i in PENDING, APPLY and DONE, with no queueing.
REQ-027 SHALL never alter active outputs other than on the clock edge ending APPLY; non-dirty outputs hold their value.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, return to IDLE from any state, clear all shadows, active outputs, dirty mask, counter and vs_prev, and drive cfg_busy_o, cfg_done_o, cfg_timeout_o and resync_o to 0.
REQ-029 SHALL, on reset during PENDING, APPLY or DONE, abort with no cfg_done_o pulse after reset deasserts.

Verification
REQ-030 SHALL cover: write sel=0 data 0x12345678, commit, falling VSYNC 100 cycles later -> hv_out_config_o=0x12345678 and cfg_done_o and resync_o pulse exactly 2 cycles after the edge-detect cycle; cfg_busy_o high from the cycle after commit until DONE.
REQ-031 SHALL cover: write sel=6 data 0xA5, commit -> sl_config_o=0xA5 and cfg_done_o pulse with resync_o=0; other outputs unchanged.
REQ-032 SHALL cover: commit with no prior writes -> cfg_done_o 1 cycle later, no resync_o, cfg_busy_o high for one cycle.
REQ-033 SHALL cover: TIMEOUT_CLKS=16, write sel=3, commit, VSYNC held high -> APPLY after 16 PENDING cycles, with cfg_done_o and cfg_timeout_o pulsing together.
REQ-034 SHALL cover: write sel=1 0x1 in the APPLY cycle of another commit -> hv_out_config2_o unchanged after DONE; a second commit plus edge -> 0x1.
REQ-035 SHALL cover: reset asserted during PENDING -> all outputs 0, no cfg_done_o, and a subsequent edge does nothing.
